hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
Pipeline control block for the 5-stage RV32I core: generates stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects. Resolves load-use hazards, branch/jump redirects and multi-cycle data-memory wait states. A wait-timeout state machine traps hung memory accesses. A saturating counter records stalled cycles for performance monitoring.

Parameters:
MAX_WAIT, 16, max consecutive MEM wait cycles before entering ERR (legal range 2..255)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
Rs1D, Rs2D  in  5  source registers of the instruction in ID
Rs1E, Rs2E, RdE  in  5  source/destination registers in EX
ResultSrcE  in  2  EX result select; 2'b01 marks a load
PCSrcE  in  1  branch-taken/jump redirect from EX
RdM, RdW  in  5  destination registers in MEM and WB
RegWriteM, RegWriteW  in  1  write enables in MEM and WB
MemReqM  in  1  load/store active in MEM
MemReadyM  in  1  data memory completes access this cycle
StallCntClr  in  1  synchronous clear of StallCount
StallF, StallD, StallE, StallM  out  1  hold PC / IF-ID / ID-EX / EX-MEM registers
FlushD, FlushE, FlushW  out  1  bubble IF-ID / ID-EX / MEM-WB registers
ForwardAE, ForwardBE  out  2  ALU operand select: 00 = regfile, 01 = WB result, 10 = MEM ALU result
MemErr  out  1  sticky memory-timeout flag
StallCount  out  CNT_W  saturating count of cycles with StallF = 1

Behaviour:
- State register values are RUN, MEM_WAIT and ERR. WaitCnt is 8 bits wide.
- While rst = 0:
  - state = RUN, WaitCnt = 0, MemErr = 0, StallCount = 0.
  - All Stall* outputs = 0, FlushD = FlushE = FlushW = 1, Forward* = 00.
- Stall and flush outputs are combinational from the current state and current inputs, so they take effect in the same cycle. State, WaitCnt, MemErr and StallCount update on the rising edge of clk.
- memwait = MemReqM & ~MemReadyM.
- loaduse = (ResultSrcE == 01) & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D).
- Priority in RUN, and in MEM_WAIT once MemReadyM = 1:
  1. memwait: StallF = StallD = StallE = StallM = 1, FlushW = 1, FlushD = FlushE = 0. Next state MEM_WAIT, WaitCnt <= 1.
  2. Else PCSrcE: FlushD = 1, FlushE = 1, no stalls. loaduse is ignored because the ID instruction is squashed.
  3. Else loaduse: StallF = StallD = 1, FlushE = 1.
  4. Else all stall/flush outputs = 0.
- MEM_WAIT:
  - MemReadyM = 1: release all stalls this cycle and apply priorities 2-4. Next state RUN, WaitCnt <= 0.
  - MemReadyM = 0 and WaitCnt < MAX_WAIT: full stall as in priority 1, WaitCnt++.
  - MemReadyM = 0 and WaitCnt == MAX_WAIT: full stall, next state ERR, MemErr <= 1.
  - A PCSrcE or loaduse condition seen during MEM_WAIT is not acted on. EX is frozen, so the condition persists and is serviced on the release cycle.
- ERR: StallF/D/E/M = 1, FlushW = 1, FlushD = FlushE = 0, MemErr = 1. The only exit is reset.
- Forwarding is active in every state:
  - ForwardAE = 10 if RegWriteM & RdM != 0 & RdM == Rs1E.
  - Else ForwardAE = 01 if RegWriteW & RdW != 0 & RdW == Rs1E.
  - Else ForwardAE = 00.
  - ForwardBE follows the same rule using Rs2E.
  - MEM has priority over WB. x0 is never forwarded.
- StallCount:
  - Increments on each edge where StallF = 1 and saturates at all-ones.
  - StallCntClr has priority over increment and loads 0.
- If reset asserts mid-wait, the state machine aborts immediately to the reset values. No pending redirect is retained.

Test Plan:
- Load-use: ResultSrcE = 01, RdE = 5, Rs2D = 5 -> StallF = StallD = FlushE = 1 for 1 cycle, StallCount = 1. Repeat with RdE = 0 -> no stall.
- Redirect + load-use same cycle: PCSrcE = 1 with the load-use condition -> FlushD = FlushE = 1, StallF = 0, StallCount unchanged.
- Memory wait: MemReqM = 1, MemReadyM low for 3 cycles then high -> full stall + FlushW for 3 cycles, release on the 4th, StallCount = 3, state back to RUN.
- Timeout: MAX_WAIT = 4, MemReadyM held 0 -> ERR entered after the 5th stalled cycle (stall cycle N sees WaitCnt = N-1, so ERR is taken on the cycle with WaitCnt = 4). MemErr = 1 and stalls remain while MemReadyM later rises. Async rst low mid-ERR -> MemErr = 0, FlushD/E/W = 1 immediately.
- Forwarding: RdM = RdW = 7, both write, Rs1E = 7 -> ForwardAE = 10. With RegWriteM = 0 -> 01. With Rs1E = 0 -> 00.
- Counter: force 0xFFFE cycles of stall -> count saturates at 0xFFFF. StallCntClr together with a stall -> 0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline control for the 5-stage RV32I core.
// Produces stall/flush enables for the pipeline registers and the EX-stage
// forwarding selects. A wait-timeout FSM traps hung data-memory accesses.
// A saturating counter tracks cycles where fetch is stalled.

module hazard_sequencer #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic             StallCntClr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0]       WAIT_LIMIT = 8'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       mem_err;
    logic       mem_err_next;
    logic       memwait;
    logic       loaduse;
    logic       full_stall;
    logic       resolve;

    assign memwait = MemReqM & ~MemReadyM;
    assign loaduse = (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                     ((RdE == Rs1D) | (RdE == Rs2D));
    assign MemErr  = mem_err;

    // Next-state logic and the same-cycle stall/flush controls; a full stall
    // freezes the pipe, otherwise redirect beats load-use
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        mem_err_next  = mem_err;
        full_stall    = 1'b0;
        resolve       = 1'b0;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushW        = 1'b0;

        unique case (state)
            RUN: begin
                if (memwait) begin
                    full_stall    = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM) begin
                    resolve       = 1'b1;
                    state_next    = RUN;
                    wait_cnt_next = 8'd0;
                end else begin
                    full_stall = 1'b1;
                    if (wait_cnt < WAIT_LIMIT) begin
                        wait_cnt_next = wait_cnt + 8'd1;
                    end else begin
                        state_next   = ERR;
                        mem_err_next = 1'b1;
                    end
                end
            end
            ERR: begin
                full_stall   = 1'b1;
                mem_err_next = 1'b1;
            end
            default: begin
                full_stall   = 1'b1;
                state_next   = ERR;
                mem_err_next = 1'b1;
            end
        endcase

        if (full_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (resolve) begin
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (loaduse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end

        if (!rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end
    end

    // Forwarding selects: MEM result beats WB result, x0 never forwarded
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
        if (!rst) begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end
    end

    // FSM state, wait counter and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            mem_err  <= mem_err_next;
        end
    end

    // Saturating stalled-fetch counter; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCount <= '0;
        end else if (StallCntClr) begin
            StallCount <= '0;
        end else if (StallF && (StallCount != CNT_MAX)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.

module tb_hazard_sequencer;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;
    localparam int CNT_TOP  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic             StallCntClr;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] StallCount;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: error flag, length of the current run of memory
    // stall cycles (0 = not waiting) and the stalled-fetch count
    bit m_err;
    int m_waited;
    int m_count;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    int e_fa, e_fb;

    hazard_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM), .StallCntClr(StallCntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic int fwdSel(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 1;
        return 0;
    endfunction

    function automatic bit pipeFrozen();
        if (m_err) return 1;
        if (m_waited > 0) return !MemReadyM;
        return MemReqM && !MemReadyM;
    endfunction

    function automatic void modelReset();
        m_err    = 0;
        m_waited = 0;
        m_count  = 0;
    endfunction

    function automatic void modelOutputs();
        bit lu;
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
        e_fa = 0;
        e_fb = 0;
        if (!rst) begin
            {e_fd, e_fe, e_fw} = 3'b111;
            return;
        end
        e_fa = fwdSel(Rs1E);
        e_fb = fwdSel(Rs2E);
        lu = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        if (pipeFrozen()) begin
            {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
        end else begin
            e_fd = PCSrcE;
            e_fe = PCSrcE || lu;
            e_sf = !PCSrcE && lu;
            e_sd = e_sf;
        end
    endfunction

    function automatic void modelClock();
        if (!rst) begin
            modelReset();
            return;
        end
        if (StallCntClr) m_count = 0;
        else if (e_sf && m_count < CNT_TOP) m_count++;
        if (!m_err) begin
            if (pipeFrozen()) begin
                m_waited++;
                if (m_waited > MAX_WAIT) m_err = 1;
            end else begin
                m_waited = 0;
            end
        end
    endfunction

    task automatic checkAll();
        modelOutputs();
        checkOutput("StallF", StallF, e_sf);
        checkOutput("StallD", StallD, e_sd);
        checkOutput("StallE", StallE, e_se);
        checkOutput("StallM", StallM, e_sm);
        checkOutput("FlushD", FlushD, e_fd);
        checkOutput("FlushE", FlushE, e_fe);
        checkOutput("FlushW", FlushW, e_fw);
        checkOutput("ForwardAE", ForwardAE, e_fa);
        checkOutput("ForwardBE", ForwardBE, e_fb);
        checkOutput("MemErr", MemErr, m_err);
        checkOutput("StallCount", StallCount, m_count);
    endtask

    // Called just after a rising edge with inputs already set: check at the
    // falling edge, advance the model, return just after the next rising edge
    task automatic applyStimulus();
        @(negedge clk);
        checkAll();
        modelClock();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE  = 2'b00;
        PCSrcE      = 1'b0;
        RegWriteM   = 1'b0;
        RegWriteW   = 1'b0;
        MemReqM     = 1'b0;
        MemReadyM   = 1'b1;
        StallCntClr = 1'b0;
    endtask

    task automatic randomInputs();
        Rs1D        = 5'($urandom_range(0, 3));
        Rs2D        = 5'($urandom_range(0, 3));
        Rs1E        = 5'($urandom_range(0, 3));
        Rs2E        = 5'($urandom_range(0, 3));
        RdE         = 5'($urandom_range(0, 3));
        RdM         = 5'($urandom_range(0, 3));
        RdW         = 5'($urandom_range(0, 3));
        ResultSrcE  = 2'($urandom_range(0, 3));
        PCSrcE      = ($urandom_range(0, 3) == 0);
        RegWriteM   = 1'($urandom_range(0, 1));
        RegWriteW   = 1'($urandom_range(0, 1));
        MemReqM     = 1'($urandom_range(0, 1));
        MemReadyM   = ($urandom_range(0, 3) != 0);
        StallCntClr = ($urandom_range(0, 15) == 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react at once
    task automatic asyncReset();
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        idleInputs();
        modelReset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus();
        rst = 1'b1;
        applyStimulus();

        // Load-use stalls one cycle, then x0 destination gives no stall
        ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5;
        #1;
        checkOutput("lu_stallf", StallF, 1);
        applyStimulus();
        checkOutput("lu_count", StallCount, 1);
        RdE = 5'd0; Rs2D = 5'd0;
        applyStimulus();

        // Redirect squashes the load-use instruction instead of stalling
        RdE = 5'd5; Rs2D = 5'd5; PCSrcE = 1'b1;
        #1;
        checkOutput("redir_stallf", StallF, 0);
        checkOutput("redir_flushd", FlushD, 1);
        applyStimulus();
        checkOutput("redir_count", StallCount, 1);
        idleInputs();
        StallCntClr = 1'b1;
        applyStimulus();
        StallCntClr = 1'b0;

        // Three memory wait cycles, release on the fourth
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (3) applyStimulus();
        MemReadyM = 1'b1;
        #1;
        checkOutput("mw_release", StallF, 0);
        applyStimulus();
        checkOutput("mw_count", StallCount, 3);
        idleInputs();
        applyStimulus();

        // Forwarding priority and x0 suppression
        RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd7;
        #1;
        checkOutput("fwd_mem", ForwardAE, 2'b10);
        applyStimulus();
        RegWriteM = 1'b0;
        #1;
        checkOutput("fwd_wb", ForwardAE, 2'b01);
        applyStimulus();
        Rs1E = 5'd0; RdW = 5'd0;
        applyStimulus();
        idleInputs();

        // Timeout: fifth stalled cycle enters the error state
        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("to_noerr", MemErr, 0);
        applyStimulus();
        checkOutput("to_err", MemErr, 1);
        MemReadyM = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("to_stuck", StallF, 1);
        asyncReset();
        checkOutput("rst_memerr", MemErr, 0);
        checkOutput("rst_flushe", FlushE, 1);
        idleInputs();
        applyStimulus();

        // Randomized traffic; recover from the error state by reset
        for (int i = 0; i < 2000; i++) begin
            randomInputs();
            if (m_err && $urandom_range(0, 3) == 0) asyncReset();
            else applyStimulus();
        end

        // Saturation: park in the error state, clear with a stall, then run
        asyncReset();
        idleInputs();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        while (!m_err) applyStimulus();
        StallCntClr = 1'b1;
        applyStimulus();
        checkOutput("clr_with_stall", StallCount, 0);
        StallCntClr = 1'b0;
        repeat (16'hFFFE) @(posedge clk);
        #1;
        m_count = 16'hFFFE;
        checkOutput("sat_pre", StallCount, 16'hFFFE);
        repeat (4) applyStimulus();
        checkOutput("sat_top", StallCount, 16'hFFFF);
        StallCntClr = 1'b1;
        applyStimulus();
        StallCntClr = 1'b0;
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
